hazard_pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. Three conditions are resolved in one place:
- load-use hazards, with a one-cycle bubble;
- taken branches and jumps, with a two-stage flush;
- multi-cycle data-memory accesses, using a ready handshake and a bounded-wait FSM.

---
 rtl/hazard_pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubble, branch flush, bounded memory wait.
// Define PIPE_PERF_CNT_EN to build the stall_cycles / flush_events performance counters.
module hazard_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic             ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic       mem_err_reg;

  logic timeout_hit;
  logic mem_hold;
  logic branch;
  logic load_use;

  assign timeout_hit = (state_reg == MEM_WAIT) && (wait_cnt_reg == TIMEOUT_LAST) && !mem_ready;
  assign mem_hold    = mem_req && !mem_ready && !timeout_hit;
  assign branch      = ex_branch_taken && !mem_hold;
  // rs2 is compared even when the ID instruction does not read it; the false stall is harmless.
  assign load_use    = ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2)) &&
                       !mem_hold && !ex_branch_taken;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_hold) begin
      // Freeze everything up to EX/MEM; feed bubbles into WB while the access is outstanding.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (branch) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready || !mem_req) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
          end else if (timeout_hit) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
            mem_err_reg  <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= 8'd0;
        end
      endcase
    end
  end

  assign mem_err    = mem_err_reg;
  assign ctrl_state = state_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_en)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (branch)
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_events = flush_cnt_reg;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl: stimulus pushes hand-written expectations, a negedge monitor checks them.
module tb_hazard_pipe_ctrl;

  localparam int CNT_W = 32;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [7:0] NRM = 8'b11111_000;
  localparam logic [7:0] RST = 8'b00000_111;
  localparam logic [7:0] HLD = 8'b00000_001;
  localparam logic [7:0] BRN = 8'b11111_110;
  localparam logic [7:0] LDU = 8'b00111_010;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush;
  logic             mem_err, ctrl_state;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  hazard_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [7:0]  ctl;
    logic        st;
    logic        err;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_idx  = 0;
  logic [31:0] tot_stall = '0;
  logic [31:0] tot_flush = '0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, expv);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what the outputs must be.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                      input logic [4:0] rd, input logic br, input logic mreq, input logic mrdy,
                      input logic [7:0] ctl, input logic st, input logic err);
    exp_t e;
    id_rs1 = rs1; id_rs2 = rs2; ex_mem_read = mr; ex_rd = rd;
    ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    e.idx = vec_idx; e.ctl = ctl; e.st = st; e.err = err;
`ifdef PIPE_PERF_CNT_EN
    e.stall = reset ? 32'd0 : tot_stall;
    e.flush = reset ? 32'd0 : tot_flush;
`else
    e.stall = 32'd0;
    e.flush = 32'd0;
`endif
    exp_q.push_back(e);
    $display("vec %0d: rst=%0b rs1=%0d rs2=%0d mr=%0b rd=%0d br=%0b req=%0b rdy=%0b exp ctl=%b st=%0b err=%0b",
             vec_idx, reset, rs1, rs2, mr, rd, br, mreq, mrdy, ctl, st, err);
    if (reset) begin
      tot_stall = '0;
      tot_flush = '0;
    end else begin
      if (!ctl[7]) tot_stall = tot_stall + 32'd1;
      if (ctl == BRN) tot_flush = tot_flush + 32'd1;
    end
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", e.idx, {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                             if_id_flush, id_ex_flush, mem_wb_flush}, {24'd0, e.ctl});
        check("ctrl_state", e.idx, {31'd0, ctrl_state}, {31'd0, e.st});
        check("mem_err", e.idx, {31'd0, mem_err}, {31'd0, e.err});
        check("stall_cycles", e.idx, stall_cycles, e.stall);
        check("flush_events", e.idx, flush_events, e.flush);
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    //     rs1 rs2 mr rd br req rdy  ctl  st err
    step(1, 2, 0, 3, 0, 0, 0, RST, 0, 0);   // reset held
    reset = 1'b0;
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 0);   // idle
    step(1, 5, 1, 5, 0, 0, 0, LDU, 0, 0);   // load-use on rs2
    step(1, 5, 0, 5, 0, 0, 0, NRM, 0, 0);   // bubble in EX, stall over
    step(0, 0, 1, 0, 0, 0, 0, NRM, 0, 0);   // load to x0: no stall
    step(7, 2, 1, 7, 0, 0, 0, LDU, 0, 0);   // load-use on rs1
    step(5, 2, 1, 5, 1, 0, 0, BRN, 0, 0);   // branch beats load-use
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 0);
    step(1, 2, 0, 3, 0, 1, 0, HLD, 0, 0);   // memory wait, 3 cycles low
    step(1, 2, 0, 3, 0, 1, 0, HLD, 1, 0);
    step(1, 2, 0, 3, 0, 1, 0, HLD, 1, 0);
    step(1, 2, 0, 3, 0, 1, 1, NRM, 1, 0);   // ready on the last-count cycle wins
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 0);
    step(1, 2, 0, 3, 1, 1, 0, HLD, 0, 0);   // hold beats branch
    step(1, 2, 0, 3, 1, 1, 1, BRN, 1, 0);   // branch acted on at release
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 0);
    step(1, 2, 0, 3, 0, 1, 0, HLD, 0, 0);   // timeout with MEM_TIMEOUT=4
    step(1, 2, 0, 3, 0, 1, 0, HLD, 1, 0);
    step(1, 2, 0, 3, 0, 1, 0, HLD, 1, 0);
    step(1, 2, 0, 3, 0, 1, 0, NRM, 1, 0);   // force release
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 1);   // mem_err now set
    step(4, 2, 1, 4, 0, 0, 0, LDU, 0, 1);
    step(1, 5, 1, 5, 0, 1, 0, HLD, 0, 1);   // hold beats load-use
    step(1, 5, 1, 5, 0, 1, 0, HLD, 1, 1);
    reset = 1'b1;                           // asynchronous reset mid-wait
    step(1, 5, 1, 5, 0, 1, 0, RST, 0, 0);
    reset = 1'b0;
    step(1, 2, 0, 3, 0, 1, 0, HLD, 0, 0);   // fresh wait starts from count 1
    step(1, 2, 0, 3, 0, 1, 0, HLD, 1, 0);
    step(1, 2, 0, 3, 0, 1, 0, HLD, 1, 0);
    step(1, 2, 0, 3, 0, 1, 0, NRM, 1, 0);
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 1);
    step(1, 2, 0, 3, 0, 0, 0, NRM, 0, 1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
